uart_mmio: RTL and testbench
============================

# uart_mmio

Memory-mapped hardware UART responder for the RudolV SoC bus, replacing bit-banged serial I/O through the mapped I/O region. It sits beside the SPRAM/BRAM memories on the pipeline's data port: decoded by the top-level wrapper (mapped region, `mem_addr[28]`), register index taken from `mem_addr[15:12]`. It contains an 8N1 transmitter, an oversampling-free mid-bit receiver, a small RX FIFO and a run-time baud divisor.

## Interface
- `CLOCK_RATE`, 24_000_000, clk frequency in Hz
- `BAUD_RATE`, 115200, reset baud rate; reset divisor = CLOCK_RATE / BAUD_RATE (208)
- `RX_DEPTH`, 4, RX FIFO entries, power of 2, ≥2
- `clk`  in  1  clock
- `rstn`  in  1  reset, synchronous, active-low
- `sel`  in  1  access targets this block (decoded externally)
- `wren`  in  1  write strobe, qualified by `sel`
- `rden`  in  1  read strobe, qualified by `sel`; reads have side effects, so only real loads assert it
- `addr`  in  4  register index
- `wdata`  in  32  write data
- `rdata`  out  32  registered read data
- `uart_rx`  in  1  serial input, asynchronous
- `uart_tx`  out  1  serial output

## Operation
- Registers: 0 DATA, 1 STATUS, 4 DIVISOR; other indices read 0, writes ignored.
- DATA write: if TX idle, loads `wdata[7:0]` and starts a frame; if busy, write dropped (no queue).
- DATA read: FIFO non-empty → `{24'b0, byte}`, pop; empty → 32'hFFFF_FFFF, no pop.
- STATUS read: bit0 tx_busy, bit1 rx_avail (FIFO non-empty), bit2 overrun, bit3 frame_err; bits 2/3 sticky, cleared by this read (value returned is pre-clear).
- DIVISOR write: `wdata[15:0]`, values <4 clamped to 4. Read returns current value.
- TX FSM: IDLE → START → DATA (8 bits, LSB first) → STOP → IDLE; each state/bit lasts exactly DIVISOR cycles; counter reloads from DIVISOR at each bit boundary (mid-frame divisor write applies from the next bit).
- RX: 2-flop synchronizer, then FSM IDLE → START → DATA → STOP. IDLE: synced low → START, wait DIVISOR/2 (floor); still low → DATA, else back to IDLE (glitch). DATA: sample 8 bits each DIVISOR cycles. STOP: sample after DIVISOR; high → push byte; low → discard, set frame_err. Return to IDLE immediately after stop sample.
- FIFO full on push: byte dropped, overrun set. Push and pop same cycle: both occur, occupancy unchanged; pop from empty with simultaneous push returns 0xFFFF_FFFF and byte stays.
- STATUS-read clear and new error set in the same cycle: flag ends set.

## Timing
- Reset values: `uart_tx`=1, `rdata`=0, FIFO empty, flags 0, DIVISOR=CLOCK_RATE/BAUD_RATE, both FSMs IDLE.
- Reset mid-frame: frame aborted, `uart_tx` high on the cycle after rstn sampled low.
- `rdata` valid the cycle after `sel&rden`; 0 on cycles following no read.
- TX: DATA write in cycle N → `uart_tx` low and tx_busy=1 from N+1; frame occupies 10·DIV cycles; tx_busy clears at N+1+10·DIV; a write in that cycle starts the next frame.
- RX: byte visible in rx_avail ≤ 3 cycles after stop-bit sample point (2 sync + push).

## Structure
- Package `uart_pkg`: register index constants (REG_DATA, REG_STATUS, REG_DIVISOR), status bit positions, DIV_MIN=4, DATA_EMPTY=32'hFFFF_FFFF.
- Sub-module `uart_rx_fifo`: synchronous FIFO, RX_DEPTH×8, push/pop/full/empty, pointer wrap via extra MSB.

## Test plan
- TX: DIV=8, write DATA 0x55 → uart_tx low 8 cycles then 1,0,1,0,1,0,1,0 each 8 cycles, stop high; tx_busy high exactly 80 cycles.
- RX: drive 0xA3 8N1 at DIV=208 → STATUS=0x2; DATA read returns 0x0000_00A3; next DATA read 0xFFFF_FFFF.
- Overrun: send 5 bytes 0x01..0x05 without reading (depth 4) → reads return 1,2,3,4; STATUS bit2 set once, clear on second STATUS read.
- Framing/glitch: stop bit low → no push, frame_err set; 3-cycle low pulse on idle line at DIV=16 → no byte, no error.
- Busy write: write 0x41 then 0x42 during frame → only 0x41 transmitted.
- Corner: DIVISOR write 1 → reads 4; reset asserted mid-TX → uart_tx=1 next cycle, STATUS=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped UART responder.
package uart_pkg;

    localparam logic [3:0] REG_DATA    = 4'd0;
    localparam logic [3:0] REG_STATUS  = 4'd1;
    localparam logic [3:0] REG_DIVISOR = 4'd4;

    localparam int unsigned ST_TX_BUSY   = 0;
    localparam int unsigned ST_RX_AVAIL  = 1;
    localparam int unsigned ST_OVERRUN   = 2;
    localparam int unsigned ST_FRAME_ERR = 3;
    localparam int unsigned ST_W         = 4;

    localparam int unsigned DIV_W      = 16;
    localparam logic [15:0] DIV_MIN    = 16'd4;
    localparam logic [31:0] DATA_EMPTY = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_e;

    // Divisors below DIV_MIN would make the half-bit wait degenerate.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous byte FIFO holding received characters until software reads them.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0] mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        do_push;
    logic        do_pop;

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: transmitter, mid-bit receiver, RX FIFO and run-time baud divisor.
module uart_mmio
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 24_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned RX_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sel,
    input  logic        wren,
    input  logic        rden,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx
);
    localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(CLOCK_RATE / BAUD_RATE);

    logic             wr_c, rd_c;
    logic [DIV_W-1:0] divisor;
    logic             overrun, frame_err;
    logic [ST_W-1:0]  status_c;
    logic             unused_wdata;

    uart_state_e      tx_state;
    logic [DIV_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic             tx_busy;

    uart_state_e      rx_state;
    logic [DIV_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_s1, rx_s2;
    logic             rx_push_c, rx_ferr_c;

    logic             fifo_pop_c, fifo_full, fifo_empty, overrun_set_c, status_clr_c;
    logic [7:0]       fifo_rdata;

    assign wr_c         = sel & wren;
    assign rd_c         = sel & rden;
    assign unused_wdata = ^wdata[31:DIV_W];
    assign tx_busy      = (tx_state != S_IDLE);

    // Transmitter: every state/bit reloads from the live divisor at its boundary.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_state <= S_IDLE;
            uart_tx  <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (wr_c && addr == REG_DATA) begin
                        tx_state <= S_START;
                        uart_tx  <= 1'b0;
                        tx_shift <= wdata[7:0];
                        tx_cnt   <= divisor - DIV_W'(1);
                    end
                end
                S_START: begin
                    if (tx_cnt == '0) begin
                        tx_state <= S_DATA;
                        uart_tx  <= tx_shift[0];
                        tx_bit   <= '0;
                        tx_cnt   <= divisor - DIV_W'(1);
                    end else begin
                        tx_cnt <= tx_cnt - DIV_W'(1);
                    end
                end
                S_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= divisor - DIV_W'(1);
                        if (tx_bit == 3'd7) begin
                            tx_state <= S_STOP;
                            uart_tx  <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            uart_tx  <= tx_shift[1];
                            tx_shift <= tx_shift >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - DIV_W'(1);
                    end
                end
                default: begin
                    if (tx_cnt == '0) tx_state <= S_IDLE;
                    else              tx_cnt   <= tx_cnt - DIV_W'(1);
                end
            endcase
        end
    end

    // Receiver: synchronise, confirm start at half a bit, then sample each bit centre.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            case (rx_state)
                S_IDLE: begin
                    if (!rx_s2) begin
                        rx_state <= S_START;
                        rx_cnt   <= (divisor >> 1) - DIV_W'(1);
                    end
                end
                S_START: begin
                    if (rx_cnt == '0) begin
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                        rx_bit   <= '0;
                        rx_cnt   <= divisor - DIV_W'(1);
                    end else begin
                        rx_cnt <= rx_cnt - DIV_W'(1);
                    end
                end
                S_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= divisor - DIV_W'(1);
                        if (rx_bit == 3'd7) rx_state <= S_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - DIV_W'(1);
                    end
                end
                default: begin
                    if (rx_cnt == '0) rx_state <= S_IDLE;
                    else              rx_cnt   <= rx_cnt - DIV_W'(1);
                end
            endcase
        end
    end

    assign rx_push_c     = (rx_state == S_STOP) && (rx_cnt == '0) && rx_s2;
    assign rx_ferr_c     = (rx_state == S_STOP) && (rx_cnt == '0) && !rx_s2;
    assign fifo_pop_c    = rd_c && (addr == REG_DATA) && !fifo_empty;
    assign overrun_set_c = rx_push_c && fifo_full && !fifo_pop_c;
    assign status_clr_c  = rd_c && (addr == REG_STATUS);

    uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (rx_push_c),
        .wdata (rx_shift),
        .pop   (fifo_pop_c),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        status_c               = '0;
        status_c[ST_TX_BUSY]   = tx_busy;
        status_c[ST_RX_AVAIL]  = !fifo_empty;
        status_c[ST_OVERRUN]   = overrun;
        status_c[ST_FRAME_ERR] = frame_err;
    end

    // Register file: read data is registered and zero on cycles without a read.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            divisor   <= DIV_RESET;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            rdata     <= '0;
        end else begin
            rdata <= '0;
            if (rd_c) begin
                case (addr)
                    REG_DATA:    rdata <= fifo_empty ? DATA_EMPTY : {24'b0, fifo_rdata};
                    REG_STATUS:  rdata <= 32'(status_c);
                    REG_DIVISOR: rdata <= {16'b0, divisor};
                    default:     rdata <= '0;
                endcase
            end
            if (wr_c && addr == REG_DIVISOR) divisor <= clamp_div(wdata[DIV_W-1:0]);
            // A new error in the clearing cycle wins over the clear.
            overrun   <= (overrun && !status_clr_c) || overrun_set_c;
            frame_err <= (frame_err && !status_clr_c) || rx_ferr_c;
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: reads queue expected rdata, a monitor pops and compares.
module tb_uart_mmio;

    logic        clk   = 1'b0;
    logic        rstn  = 1'b0;
    logic        sel   = 1'b0;
    logic        wren  = 1'b0;
    logic        rden  = 1'b0;
    logic [3:0]  addr  = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        uart_rx = 1'b1;
    logic        uart_tx;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];
    logic        pend   = 1'b0;
    logic        mon_en = 1'b0;

    localparam logic [3:0] A_DATA = 4'd0;
    localparam logic [3:0] A_STAT = 4'd1;
    localparam logic [3:0] A_DIV  = 4'd4;

    uart_mmio #(.CLOCK_RATE(24_000_000), .BAUD_RATE(115200), .RX_DEPTH(4)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .sel     (sel),
        .wren    (wren),
        .rden    (rden),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) pend <= sel & rden;

    // Monitor: a read sampled on the last edge must present the queued value, else rdata is 0.
    always @(negedge clk) begin
        if (mon_en) begin
            if (pend) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rdata_unexpected: got %h expected none", rdata);
                end else begin
                    check("rdata", rdata, exp_q.pop_front());
                end
            end else begin
                check("rdata_idle", rdata, 32'd0);
            end
        end
    end

    task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; wren = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; wren = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] a, input logic [31:0] e);
        @(negedge clk);
        sel = 1'b1; rden = 1'b1; addr = a;
        exp_q.push_back(e);
        @(negedge clk);
        sel = 1'b0; rden = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input int div, input logic stop);
        uart_rx = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (div) @(negedge clk);
        end
        uart_rx = stop;
        repeat (div) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] fr;
        logic [9:0] cap;
        logic       low_seen;

        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        check("reset_tx", 32'(uart_tx), 32'd1);
        rstn = 1'b1;

        reg_read(A_STAT, 32'h0);
        reg_read(A_DIV, 32'd208);
        reg_read(A_DATA, 32'hFFFF_FFFF);

        // Receive at the reset baud rate.
        @(negedge clk);
        send_frame(8'hA3, 208, 1'b1);
        repeat (8) @(negedge clk);
        reg_read(A_STAT, 32'h2);
        reg_read(A_DATA, 32'h0000_00A3);
        reg_read(A_DATA, 32'hFFFF_FFFF);

        // Overrun: five bytes into a four-entry FIFO.
        reg_write(A_DIV, 32'd16);
        reg_read(A_DIV, 32'd16);
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 16, 1'b1);
        repeat (8) @(negedge clk);
        reg_read(A_STAT, 32'h6);
        reg_read(A_STAT, 32'h2);
        for (int b = 1; b <= 4; b++) reg_read(A_DATA, 32'(b));
        reg_read(A_DATA, 32'hFFFF_FFFF);

        // Framing error, then a short glitch on the idle line.
        send_frame(8'h5A, 16, 1'b0);
        repeat (20) @(negedge clk);
        reg_read(A_STAT, 32'h8);
        reg_read(A_STAT, 32'h0);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        reg_read(A_STAT, 32'h0);
        reg_read(A_DATA, 32'hFFFF_FFFF);

        // Divisor clamping and upper-bit masking.
        reg_write(A_DIV, 32'd1);
        reg_read(A_DIV, 32'd4);
        reg_write(A_DIV, 32'h0003_0009);
        reg_read(A_DIV, 32'd9);
        reg_write(A_DIV, 32'd8);
        reg_read(A_DIV, 32'd8);

        // Transmit 0x55 at DIV=8, polling busy every cycle.
        fr = {1'b1, 8'h55, 1'b0};
        reg_write(A_DATA, 32'h55);
        for (int s = 0; s <= 80; s++) begin
            check("tx_bit", 32'(uart_tx), (s < 80) ? 32'(fr[s/8]) : 32'd1);
            sel = 1'b1; rden = 1'b1; addr = A_STAT;
            exp_q.push_back((s < 80) ? 32'h1 : 32'h0);
            @(negedge clk);
        end
        sel = 1'b0; rden = 1'b0;

        // Second DATA write during a frame is dropped.
        cap = '0;
        low_seen = 1'b0;
        reg_write(A_DATA, 32'h41);
        for (int s = 0; s < 96; s++) begin
            if (s < 80 && (s % 8) == 4) cap[s/8] = uart_tx;
            if (s >= 80 && !uart_tx) low_seen = 1'b1;
            if (s == 20) begin
                sel = 1'b1; wren = 1'b1; addr = A_DATA; wdata = 32'h42;
            end else begin
                sel = 1'b0; wren = 1'b0;
            end
            @(negedge clk);
        end
        check("busy_frame", 32'(cap), 32'({1'b1, 8'h41, 1'b0}));
        check("busy_no_second", 32'(low_seen), 32'd0);
        reg_read(A_STAT, 32'h0);

        // Reset in the middle of a frame.
        reg_write(A_DIV, 32'd8);
        reg_write(A_DATA, 32'h00);
        repeat (20) @(negedge clk);
        check("midframe_tx", 32'(uart_tx), 32'd0);
        rstn = 1'b0;
        @(negedge clk);
        check("reset_midframe_tx", 32'(uart_tx), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        reg_read(A_STAT, 32'h0);
        reg_read(A_DIV, 32'd208);

        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
